// File: rtl/mul_spi_master_pkg.sv
// Shared types for the serial multiplier SPI master.
// Operand width, packet layout and master state encoding.
package mul_spi_master_pkg;

   localparam int REGISTER_SIZE = 8;
   localparam int PACKET_SIZE   = 2 * REGISTER_SIZE;

   // op_1 occupies the LSBs so it is serialised first
   typedef struct packed {
      logic [REGISTER_SIZE-1:0] op_2;
      logic [REGISTER_SIZE-1:0] op_1;
   } MulPacket;

   typedef enum logic [2:0] {
      MS_IDLE,
      MS_SELECT,
      MS_START,
      MS_TX,
      MS_WAIT,
      MS_ACK,
      MS_RX,
      MS_DONE
   } mul_master_state_t;

endpackage

// File: rtl/mul_spi_master_if.sv
// Shared SPI bus: per-slave select vector plus one data line
// in each direction.
interface mul_spi_master_if #(
   parameter int NssWidth = 1
);

   logic [NssWidth-1:0] nss;
   logic                mosi;
   logic                miso;

   modport master (
      output nss,
      output mosi,
      input  miso
   );

   modport slave (
      input  nss,
      input  mosi,
      output miso
   );

endinterface

// File: rtl/mul_spi_master_shift_reg.sv
// LSB-first shift register: parallel load, shift toward bit 0,
// new serial bit enters at the MSB.
module mul_spi_master_shift_reg #(
   parameter int Width = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [Width-1:0] load_data,
   input  logic             shift,
   input  logic             serial_in,
   output logic [Width-1:0] data
);

   // load wins over shift; bit 0 is the next bit on the wire
   always_ff @(posedge clock) begin
      if (reset) begin
         data <= '0;
      end else if (load) begin
         data <= load_data;
      end else if (shift) begin
         data <= {serial_in, data[Width-1:1]};
      end
   end

endmodule

// File: rtl/mul_spi_master.sv
// SPI master for the serial multiplier slave: select, start bit,
// operand serialisation, wait/ack handshake, result capture.
module mul_spi_master
   import mul_spi_master_pkg::*;
#(
   parameter int NssWidth    = 1,
   parameter int NssPosition = 0
) (
   input  logic                     i_clock,
   input  logic                     i_reset,
   input  logic                     i_valid,
   output logic                     o_ready,
   input  logic [REGISTER_SIZE-1:0] i_op_1,
   input  logic [REGISTER_SIZE-1:0] i_op_2,
   output logic [REGISTER_SIZE-1:0] o_result,
   output logic                     o_result_valid,
   output logic                     o_busy,
   mul_spi_master_if.master         spi
);

   localparam int W    = REGISTER_SIZE;
   localparam int P    = PACKET_SIZE;
   localparam int CntW = $clog2(W);

   localparam logic [2:0] ST_IDLE   = MS_IDLE;
   localparam logic [2:0] ST_SELECT = MS_SELECT;
   localparam logic [2:0] ST_START  = MS_START;
   localparam logic [2:0] ST_TX     = MS_TX;
   localparam logic [2:0] ST_WAIT   = MS_WAIT;
   localparam logic [2:0] ST_ACK    = MS_ACK;
   localparam logic [2:0] ST_RX     = MS_RX;
   localparam logic [2:0] ST_DONE   = MS_DONE;

   logic [2:0]          state;
   logic [2:0]          next_state;
   logic [CntW-1:0]     rx_cnt;
   logic [P:0]          tx_data;
   logic [W-1:0]        rx_data;
   logic [W-1:0]        result_q;
   logic [NssWidth-1:0] nss_v;
   logic                mosi_v;
   MulPacket            packet;
   logic                accept;
   logic                tx_last;
   logic                rx_last;
   logic                selected;

   assign packet   = '{op_2: i_op_2, op_1: i_op_1};
   assign accept   = i_valid && (state == ST_IDLE);
   assign selected = (state != ST_IDLE) && (state != ST_DONE);

   // A marker bit sits above the packet; once only the marker is
   // left above bit 0, the last packet bit is on the wire.
   assign tx_last = (tx_data[P:1] == P'(1));
   assign rx_last = (rx_cnt == CntW'(W - 1));

   mul_spi_master_shift_reg #(
      .Width (P + 1)
   ) u_tx (
      .clock     (i_clock),
      .reset     (i_reset),
      .load      (accept),
      .load_data ({1'b1, packet}),
      .shift     (state == ST_TX),
      .serial_in (1'b0),
      .data      (tx_data)
   );

   mul_spi_master_shift_reg #(
      .Width (W)
   ) u_rx (
      .clock     (i_clock),
      .reset     (i_reset),
      .load      (accept),
      .load_data ('0),
      .shift     (state == ST_RX),
      .serial_in (spi.miso),
      .data      (rx_data)
   );

   // Transaction sequencing
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:   if (i_valid) next_state = ST_SELECT;
         ST_SELECT: next_state = ST_START;
         ST_START:  next_state = ST_TX;
         ST_TX:     if (tx_last) next_state = ST_WAIT;
         ST_WAIT:   if (spi.miso) next_state = ST_ACK;
         ST_ACK:    next_state = ST_RX;
         ST_RX:     if (rx_last) next_state = ST_DONE;
         ST_DONE:   next_state = ST_IDLE;
         default:   next_state = ST_IDLE;
      endcase
   end

   // State register; reset aborts any transaction in flight
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Result bit counter, wraps to 0 after the last bit
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         rx_cnt <= '0;
      end else if (state == ST_RX) begin
         rx_cnt <= rx_last ? '0 : rx_cnt + 1'b1;
      end else begin
         rx_cnt <= '0;
      end
   end

   // Holds the last product while the shifter refills
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         result_q <= '0;
      end else if (state == ST_DONE) begin
         result_q <= rx_data;
      end
   end

   // mosi is high only for start, data and the wait hold
   always_comb begin
      mosi_v = 1'b0;
      case (state)
         ST_START: mosi_v = 1'b1;
         ST_TX:    mosi_v = tx_data[0];
         ST_WAIT:  mosi_v = 1'b1;
         default:  mosi_v = 1'b0;
      endcase
   end

   // Only our own select bit ever goes low
   always_comb begin
      nss_v              = '1;
      nss_v[NssPosition] = ~selected;
   end

   assign spi.nss        = nss_v;
   assign spi.mosi       = mosi_v;
   assign o_ready        = (state == ST_IDLE);
   assign o_busy         = (state != ST_IDLE);
   assign o_result_valid = (state == ST_DONE);
   assign o_result       = (state == ST_DONE) ? rx_data : result_q;

endmodule

// File: tb/tb_mul_spi_master.sv
// Scoreboard bench for mul_spi_master with a behavioural
// multiplier slave and a second, stalled, 4-bit-select instance.
module tb_mul_spi_master;
   import mul_spi_master_pkg::*;

   localparam int W   = REGISTER_SIZE;
   localparam int P   = PACKET_SIZE;
   localparam int LAT = 6 + P + W;

   logic         clk = 1'b0;
   logic         rst;
   logic         valid;
   logic         ready;
   logic [W-1:0] op1;
   logic [W-1:0] op2;
   logic [W-1:0] result;
   logic         rvalid;
   logic         busy;

   logic         rst2;
   logic         valid2;
   logic         ready2;
   logic [W-1:0] result2;
   logic         rvalid2;
   logic         busy2;

   int pass_cnt = 0;
   int total    = 0;
   int cyc      = 0;
   int acc_cyc  = 0;

   typedef struct {
      logic [W-1:0] res;
      int           acc;
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   mul_spi_master_if #(.NssWidth(1)) bus ();
   mul_spi_master_if #(.NssWidth(4)) bus2 ();

   mul_spi_master #(
      .NssWidth    (1),
      .NssPosition (0)
   ) dut (
      .i_clock        (clk),
      .i_reset        (rst),
      .i_valid        (valid),
      .o_ready        (ready),
      .i_op_1         (op1),
      .i_op_2         (op2),
      .o_result       (result),
      .o_result_valid (rvalid),
      .o_busy         (busy),
      .spi            (bus)
   );

   mul_spi_master #(
      .NssWidth    (4),
      .NssPosition (2)
   ) dut2 (
      .i_clock        (clk),
      .i_reset        (rst2),
      .i_valid        (valid2),
      .o_ready        (ready2),
      .i_op_1         (op1),
      .i_op_2         (op2),
      .o_result       (result2),
      .o_result_valid (rvalid2),
      .o_busy         (busy2),
      .spi            (bus2)
   );

   assign bus2.miso = 1'b0;

   // Behavioural multiplier slave
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ARM  = 3'd1;
   localparam logic [2:0] S_RECV = 3'd2;
   localparam logic [2:0] S_OPER = 3'd3;
   localparam logic [2:0] S_SEND = 3'd4;
   localparam logic [2:0] S_OUT  = 3'd5;

   logic [2:0]   sst = S_IDLE;
   logic [P-1:0] s_pkt = '0;
   logic [W-1:0] s_res = '0;
   int           s_cnt = 0;

   always @(posedge clk) begin
      if (rst || bus.nss[0]) begin
         sst   <= S_IDLE;
         s_cnt <= 0;
      end else begin
         case (sst)
            S_IDLE: if (!bus.mosi) sst <= S_ARM;
            S_ARM: begin
               if (bus.mosi) begin
                  sst   <= S_RECV;
                  s_cnt <= 0;
               end
            end
            S_RECV: begin
               s_pkt <= {bus.mosi, s_pkt[P-1:1]};
               s_cnt <= s_cnt + 1;
               if (s_cnt == P - 1) sst <= S_OPER;
            end
            S_OPER: begin
               s_res <= W'(s_pkt[W-1:0] * s_pkt[P-1:W]);
               sst   <= S_SEND;
            end
            S_SEND: begin
               if (!bus.mosi) begin
                  sst   <= S_OUT;
                  s_cnt <= 0;
               end
            end
            S_OUT: begin
               s_res <= s_res >> 1;
               s_cnt <= s_cnt + 1;
               if (s_cnt == W - 1) sst <= S_IDLE;
            end
            default: sst <= S_IDLE;
         endcase
      end
   end

   assign bus.miso = (sst == S_SEND) ? 1'b1 :
                     (sst == S_OUT)  ? s_res[0] : 1'b0;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: pop and compare on every result pulse
   always @(negedge clk) begin
      exp_t e;
      if (rvalid) begin
         if (q.size() == 0) begin
            check("unexpected_valid", 32'd1, 32'd0);
         end else begin
            e = q.pop_front();
            check("result", 32'(result), 32'(e.res));
            check("latency", 32'(cyc - e.acc + 1), 32'(LAT));
            check("nss_high_done", 32'(bus.nss), 32'd1);
         end
      end
   end

   task automatic request(input logic [W-1:0] a,
                          input logic [W-1:0] b,
                          input logic [W-1:0] e,
                          input bit hold);
      int n = 0;
      op1   = a;
      op2   = b;
      valid = 1'b1;
      while (!ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!ready) begin
         check("accept_timeout", 32'd0, 32'd1);
         valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      q.push_back('{res: e, acc: cyc});
      if (!hold) valid = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (q.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("drain", 32'(q.size()), 32'd0);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [P-1:0] tx_seen;
      int           a1;
      int           a2;
      int           bad;

      rst    = 1'b1;
      rst2   = 1'b1;
      valid  = 1'b0;
      valid2 = 1'b0;
      op1    = '0;
      op2    = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rvalid", 32'(rvalid), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_nss", 32'(bus.nss), 32'd1);
      check("rst_mosi", 32'(bus.mosi), 32'd0);
      check("rst_nss2", 32'(bus2.nss), 32'hF);
      @(negedge clk);
      rst  = 1'b0;
      rst2 = 1'b0;

      // basic 3*5 with framing and bit order
      @(negedge clk);
      request(8'd3, 8'd5, 8'd15, 1'b0);
      @(negedge clk);
      check("select_nss", 32'(bus.nss), 32'd0);
      check("select_mosi", 32'(bus.mosi), 32'd0);
      @(negedge clk);
      check("start_mosi", 32'(bus.mosi), 32'd1);
      for (int k = 0; k < P; k++) begin
         @(negedge clk);
         tx_seen[k] = bus.mosi;
      end
      check("tx_bits", 32'(tx_seen), 32'h0503);
      wait_done();
      check("slave_pkt", 32'(s_pkt), 32'h0503);

      // truncation, ready low for the whole transaction
      @(negedge clk);
      request(8'hFF, 8'hFF, 8'h01, 1'b0);
      bad = 0;
      for (int i = 1; i < LAT; i++) begin
         if (ready || !busy) bad++;
         @(posedge clk);
         #1;
      end
      check("ready_low", 32'(bad), 32'd0);
      wait_done();

      // back-to-back with valid held
      @(negedge clk);
      request(8'd7, 8'd6, 8'd42, 1'b1);
      a1 = acc_cyc;
      request(8'd0, 8'd9, 8'd0, 1'b0);
      a2 = acc_cyc;
      check("b2b_gap", 32'(a2 - a1), 32'(LAT + 1));
      wait_done();

      // new request while busy is ignored
      @(negedge clk);
      request(8'd12, 8'd11, 8'd132, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      op1   = 8'd1;
      op2   = 8'd1;
      valid = 1'b1;
      check("ready_busy", 32'(ready), 32'd0);
      repeat (5) @(negedge clk);
      check("ready_busy2", 32'(ready), 32'd0);
      valid = 1'b0;
      wait_done();
      repeat (3) @(negedge clk);
      check("idle_after", 32'(busy), 32'd0);

      // reset during TX
      @(negedge clk);
      request(8'd9, 8'd9, 8'd81, 1'b0);
      repeat (7) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      q.delete();
      check("mid_rst_nss", 32'(bus.nss), 32'd1);
      check("mid_rst_mosi", 32'(bus.mosi), 32'd0);
      check("mid_rst_ready", 32'(ready), 32'd1);
      check("mid_rst_rvalid", 32'(rvalid), 32'd0);
      check("mid_rst_result", 32'(result), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      request(8'd2, 8'd2, 8'd4, 1'b0);
      wait_done();

      // 4-bit select, slave never answers
      @(negedge clk);
      op1    = 8'd3;
      op2    = 8'd3;
      valid2 = 1'b1;
      check("ready2", 32'(ready2), 32'd1);
      @(posedge clk);
      #1;
      valid2 = 1'b0;
      bad    = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bus2.nss != 4'b1011 || rvalid2) bad++;
      end
      check("nss2_pattern", 32'(bad), 32'd0);
      check("mosi2_wait", 32'(bus2.mosi), 32'd1);
      check("busy2_wait", 32'(busy2), 32'd1);
      rst2 = 1'b1;
      @(posedge clk);
      #1;
      check("rst2_nss", 32'(bus2.nss), 32'hF);
      check("rst2_mosi", 32'(bus2.mosi), 32'd0);
      rst2 = 1'b0;

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
